// File: rtl/dso_pkg.sv
// Shared widths and helpers for the DSO sample path.
package dso_pkg;

  localparam int FIR_OUT_W      = 20;
  localparam int DSO_SAMPLE_W   = 8;
  localparam int FIR_GAIN_SHIFT = 7;

  // Smallest r such that 2**r >= n; usable in constant expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Register-based synchronous FIFO with occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo
  import dso_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [clog2(DEPTH):0]  level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  // Force the head to zero when empty so the output is defined without resetting storage.
  assign rdata = empty ? '0 : mem[rd_ptr];

  // Sample storage.
  // NOTE: storage is not reset; pointers and level define validity, so a memory reset buys nothing.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two; level tracks occupancy.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/fir_out_packer.sv
// FIR output consumer: round, rescale and clip each result to an unsigned
// display sample, buffer it, and account for samples lost to a full FIFO.
module fir_out_packer
  import dso_pkg::*;
#(
  parameter int IN_W  = FIR_OUT_W,
  parameter int OUT_W = DSO_SAMPLE_W,
  parameter int SHIFT = FIR_GAIN_SHIFT,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  input  logic [IN_W-1:0]       in_data,
  input  logic                  clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic [clog2(DEPTH):0] level,
  output logic                  sat_pulse,
  output logic                  ovf,
  output logic [CNT_W-1:0]      drop_cnt
);

  // Half an output LSB, added before the shift to round half-up.
  localparam logic [IN_W:0] RND = (IN_W + 1)'(1) << (SHIFT - 1);

  logic [IN_W:0]        r1;
  logic                 v1;
  logic signed [IN_W:0] q;
  logic [OUT_W-1:0]     res_c;
  logic                 sat_c;
  logic [OUT_W-1:0]     res2;
  logic                 sat2;
  logic                 v2;
  logic                 full;
  logic                 empty;
  logic                 pop;
  logic                 drop;

  // Stage 1: sign-extend by one bit so adding the rounding constant cannot overflow.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      v1 <= 1'b0;
      r1 <= '0;
    end else begin
      v1 <= in_valid;
      r1 <= {in_data[IN_W-1], in_data} + RND;
    end
  end

  // Arithmetic shift, then clip to the unsigned output range.
  // NOTE: combinational logic uses blocking '=' and defaults every output first so no latch is inferred.
  always_comb begin
    q     = $signed(r1) >>> SHIFT;
    res_c = q[OUT_W-1:0];
    sat_c = 1'b0;
    if (q[IN_W]) begin
      res_c = '0;
      sat_c = 1'b1;
    end else if (|q[IN_W-1:OUT_W]) begin
      res_c = '1;
      sat_c = 1'b1;
    end
  end

  // Stage 2: register the clipped sample; it is pushed into the FIFO on the following edge.
  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      v2   <= 1'b0;
      res2 <= '0;
      sat2 <= 1'b0;
    end else begin
      v2   <= v1;
      res2 <= res_c;
      sat2 <= sat_c;
    end
  end

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign drop      = v2 && full && !pop;

  sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (v2),
    .pop   (pop),
    .wdata (res2),
    .rdata (out_data),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // Saturation pulse aligned with the push; sticky overflow and saturating drop count, clr wins except over a same-cycle drop.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sat_pulse <= 1'b0;
      ovf       <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      sat_pulse <= v2 && sat2;
      if (clr) begin
        ovf      <= drop;
        drop_cnt <= CNT_W'(drop);
      end else if (drop) begin
        ovf <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule
